// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray counter with load, wrap/saturate mode and terminal-count pulse.
// Binary state is the source of truth; the Gray output is registered from the same next value.
module gray_updown_counter #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] bin_count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] next_bin;
  logic             next_tc;
  logic             at_max;
  logic             at_min;

  assign at_max = (bin_count == {WIDTH{1'b1}});
  assign at_min = (bin_count == {WIDTH{1'b0}});

  always_comb begin
    next_bin = bin_count;
    next_tc  = 1'b0;
    if (load) begin
      next_bin = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          next_tc = 1'b1;
          if (WRAP) next_bin = {WIDTH{1'b0}};
        end else begin
          next_bin = bin_count + ONE;
        end
      end else begin
        if (at_min) begin
          next_tc = 1'b1;
          if (WRAP) next_bin = {WIDTH{1'b1}};
        end else begin
          next_bin = bin_count - ONE;
        end
      end
    end
  end

  // Gray is derived from next_bin so count and bin_count always change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_count <= {WIDTH{1'b0}};
      count     <= {WIDTH{1'b0}};
      tc        <= 1'b0;
    end else begin
      bin_count <= next_bin;
      count     <= next_bin ^ (next_bin >> 1);
      tc        <= next_tc;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench for gray_updown_counter: one wrapping and one saturating instance.
module tb_gray_updown_counter;

  logic       clk;
  logic       reset;
  logic       en, up_dn, load;
  logic [7:0] load_val;
  logic [7:0] count, bin_count;
  logic       tc;

  logic       en_s, up_s, load_s;
  logic [7:0] lv_s;
  logic [7:0] count_s, bin_s;
  logic       tc_s;

  int total  = 0;
  int passed = 0;

  gray_updown_counter #(.WIDTH(8), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count), .bin_count(bin_count), .tc(tc)
  );

  gray_updown_counter #(.WIDTH(8), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .en(en_s), .up_dn(up_s), .load(load_s),
    .load_val(lv_s), .count(count_s), .bin_count(bin_s), .tc(tc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic [7:0] exp_bin;
    logic [7:0] exp_gray;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev, eb;

    vecs[0]  = '{1'b1, 8'd0,   1'b0, 1'b1, 8'd0,   8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd1,   8'h01, 1'b0};
    vecs[2]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd2,   8'h03, 1'b0};
    vecs[3]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd3,   8'h02, 1'b0};
    vecs[4]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd4,   8'h06, 1'b0};
    vecs[5]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd5,   8'h07, 1'b0};
    vecs[6]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd6,   8'h05, 1'b0};
    vecs[7]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd7,   8'h04, 1'b0};
    vecs[8]  = '{1'b0, 8'd0,   1'b0, 1'b1, 8'd7,   8'h04, 1'b0};
    vecs[9]  = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd6,   8'h05, 1'b0};
    vecs[10] = '{1'b1, 8'd10,  1'b1, 1'b1, 8'd10,  8'h0F, 1'b0};
    vecs[11] = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd11,  8'h0E, 1'b0};
    vecs[12] = '{1'b1, 8'd255, 1'b0, 1'b1, 8'd255, 8'h80, 1'b0};
    vecs[13] = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd0,   8'h00, 1'b1};
    vecs[14] = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd1,   8'h01, 1'b0};
    vecs[15] = '{1'b1, 8'd0,   1'b1, 1'b0, 8'd0,   8'h00, 1'b0};
    vecs[16] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'hFF,  8'h80, 1'b1};
    vecs[17] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'hFE,  8'h81, 1'b0};
    vecs[18] = '{1'b1, 8'd100, 1'b0, 1'b0, 8'd100, 8'h56, 1'b0};
    vecs[19] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd99,  8'h52, 1'b0};

    reset = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = 8'd0;
    en_s = 1'b0; up_s = 1'b1; load_s = 1'b0; lv_s = 8'd0;

    // Reset held with en=1 across several edges
    #30;
    check("rst_count", {24'd0, count}, 32'h0);
    check("rst_bin", {24'd0, bin_count}, 32'h0);
    check("rst_tc", {31'd0, tc}, 32'h0);
    check("rst_sat_bin", {24'd0, bin_s}, 32'h0);
    #2 reset = 1'b1;
    tick();
    check("first_step_count", {24'd0, count}, 32'h01);
    check("first_step_bin", {24'd0, bin_count}, 32'h01);

    for (int i = 0; i < 20; i++) begin
      load = vecs[i].load; load_val = vecs[i].lv; en = vecs[i].en; up_dn = vecs[i].up;
      tick();
      check($sformatf("vec%0d_bin", i), {24'd0, bin_count}, {24'd0, vecs[i].exp_bin});
      check($sformatf("vec%0d_gray", i), {24'd0, count}, {24'd0, vecs[i].exp_gray});
      check($sformatf("vec%0d_tc", i), {31'd0, tc}, {31'd0, vecs[i].exp_tc});
    end

    // Full up sweep with wrap: one bit changes per step
    load = 1'b1; load_val = 8'd0; en = 1'b0; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    prev = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tick();
      eb = 8'(i + 1);
      check($sformatf("sweep%0d_bin", i), {24'd0, bin_count}, {24'd0, eb});
      check($sformatf("sweep%0d_gray", i), {24'd0, count}, {24'd0, eb ^ (eb >> 1)});
      check($sformatf("sweep%0d_onebit", i), $countones(count ^ prev), 32'd1);
      check($sformatf("sweep%0d_tc", i), {31'd0, tc}, (i == 255) ? 32'd1 : 32'd0);
      prev = count;
    end
    en = 1'b0;

    // Saturate at the top
    load_s = 1'b1; lv_s = 8'd254; en_s = 1'b0; up_s = 1'b1;
    tick();
    load_s = 1'b0; en_s = 1'b1;
    tick();
    check("sat_up_reach_bin", {24'd0, bin_s}, 32'd255);
    check("sat_up_reach_tc", {31'd0, tc_s}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_up%0d_gray", i), {24'd0, count_s}, 32'h80);
      check($sformatf("sat_up%0d_bin", i), {24'd0, bin_s}, 32'd255);
      check($sformatf("sat_up%0d_tc", i), {31'd0, tc_s}, 32'd1);
    end
    en_s = 1'b0;
    tick();
    check("sat_up_release_tc", {31'd0, tc_s}, 32'd0);

    // Saturate at the bottom
    load_s = 1'b1; lv_s = 8'd1; up_s = 1'b0;
    tick();
    load_s = 1'b0; en_s = 1'b1;
    tick();
    check("sat_dn_reach_bin", {24'd0, bin_s}, 32'd0);
    check("sat_dn_reach_tc", {31'd0, tc_s}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_dn%0d_gray", i), {24'd0, count_s}, 32'h00);
      check($sformatf("sat_dn%0d_bin", i), {24'd0, bin_s}, 32'd0);
      check($sformatf("sat_dn%0d_tc", i), {31'd0, tc_s}, 32'd1);
    end
    en_s = 1'b0;

    // Asynchronous reset between edges while counting
    load = 1'b1; load_val = 8'd100; en = 1'b1; up_dn = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("pre_areset_bin", {24'd0, bin_count}, 32'd101);
    #1 reset = 1'b0;
    #1;
    check("areset_count", {24'd0, count}, 32'h0);
    check("areset_bin", {24'd0, bin_count}, 32'h0);
    check("areset_tc", {31'd0, tc}, 32'h0);
    #1 reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      eb = 8'(i);
      check($sformatf("resume%0d_bin", i), {24'd0, bin_count}, {24'd0, eb});
      check($sformatf("resume%0d_gray", i), {24'd0, count}, {24'd0, eb ^ (eb >> 1)});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
